// File: rtl/pkt_drv_pkg.sv
// Shared definitions for the packet operand driver.
//   state_t : run-control states
//   CNT_W   : width of the transaction counter and the checksum
//   pkt_w() : packet width for a given operand width and pair count
package pkt_drv_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Each packet carries PAIRS operand pairs (A then B) of DATA_W bits each.
    function automatic int pkt_w(input int data_w, input int pairs);
        return 2 * data_w * pairs;
    endfunction

endpackage

// File: rtl/pkt_drv_fifo.sv
// pkt_fifo: synchronous packet FIFO.
//   clk_i, reset_i : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata    : write strobe and data (caller never pushes when full)
//   pop, rdata     : read strobe and head-of-queue data (caller never pops when empty)
//   full, empty    : occupancy flags
module pkt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which entries are valid, so clearing them empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pkt_operand_driver.sv
// pkt_operand_driver: buffers wide packets, slices them into operand pairs,
// drives them over a valid/ready handshake, counts LENGTH transactions,
// accumulates a result checksum, drains, then flags done.
//   pkt_valid_i/pkt_ready_o/pkt_data_i : packet input port
//   start_i, loop_i                     : run start, replay-on-empty select
//   a_o/b_o/op_valid_o/op_ready_i       : operand output port
//   res_i/res_valid_i                   : result strobe from the DUT
//   count_o, checksum_o                 : completed transactions, result sum
//   busy_o, done_o, underrun_o          : run status, sticky stall flag
module pkt_operand_driver
    import pkt_drv_pkg::*;
#(
    parameter int          DATA_W = 8,
    parameter int          PAIRS  = 16,
    parameter int          DEPTH  = 4,
    parameter int unsigned LENGTH = 2000,
    parameter int          DRAIN  = 2,
    localparam int         PKT_W  = pkt_w(DATA_W, PAIRS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              pkt_valid_i,
    output logic              pkt_ready_o,
    input  logic [PKT_W-1:0]  pkt_data_i,
    input  logic              start_i,
    input  logic              loop_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              op_valid_o,
    input  logic              op_ready_i,
    input  logic [DATA_W-1:0] res_i,
    input  logic              res_valid_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  checksum_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o
);

    localparam int                IDX_W       = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(PAIRS - 1);
    localparam logic [CNT_W-1:0]  FINAL_COUNT = CNT_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST  = CNT_W'(DRAIN - 1);

    state_t           state;
    state_t           state_next;
    logic             run_start;
    logic [PKT_W-1:0] cur;
    logic [PKT_W-1:0] fifo_rdata;
    logic             cur_valid;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] drain_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             load;
    logic             handshake;
    logic             last_pair;
    logic             final_hs;

    pkt_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (push),
        .wdata   (pkt_data_i),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pkt_ready_o = !fifo_full;
    assign push        = pkt_valid_i && !fifo_full;
    assign op_valid_o  = (state == ST_RUN) && cur_valid;
    assign handshake   = op_valid_o && op_ready_i;
    assign last_pair   = (idx == LAST_IDX);
    assign final_hs    = handshake && (count_o == FINAL_COUNT);
    // Refill an empty operand slot, or chain straight into the next packet on
    // the last pair so the stream stays gapless; never pop past the last transaction.
    assign load        = (state == ST_RUN) && !cur_valid && !fifo_empty;
    assign pop         = load || (handshake && last_pair && !fifo_empty && !final_hs);
    assign busy_o      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done_o      = (state == ST_DONE);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        a_o = '0;
        b_o = '0;
        for (int k = 0; k < PAIRS; k++) begin
            if (idx == IDX_W'(k)) begin
                a_o = cur[2*k*DATA_W +: DATA_W];
                b_o = cur[(2*k+1)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_next = state;
        run_start  = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_next = ST_RUN;
                    run_start  = 1'b1;
                end
            end
            ST_RUN:   if (final_hs) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cur        <= '0;
            cur_valid  <= 1'b0;
            idx        <= '0;
            count_o    <= '0;
            checksum_o <= '0;
            underrun_o <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + CNT_W'(1) : '0;
            if (run_start) begin
                cur_valid  <= 1'b0;
                idx        <= '0;
                count_o    <= '0;
                checksum_o <= '0;
                underrun_o <= 1'b0;
            end else begin
                if (busy_o && res_valid_i) checksum_o <= checksum_o + CNT_W'(res_i);
                if (load) begin
                    cur       <= fifo_rdata;
                    cur_valid <= 1'b1;
                    idx       <= '0;
                end else if (handshake) begin
                    count_o <= count_o + CNT_W'(1);
                    if (!last_pair) begin
                        idx <= idx + IDX_W'(1);
                    end else if (!fifo_empty) begin
                        if (!final_hs) cur <= fifo_rdata;
                        idx <= '0;
                    end else if (loop_i) begin
                        idx <= '0;
                    end else begin
                        // Starved: drop the slot and wait for the next push.
                        cur_valid  <= 1'b0;
                        underrun_o <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_operand_driver.sv
// Self-checking bench for pkt_operand_driver (DATA_W=8, PAIRS=2, DEPTH=2,
// LENGTH=6, DRAIN=2). Expected operand streams are built from the packets
// pushed and the replay/stall rules; handshakes are recorded as observed.
module tb_pkt_operand_driver;

    localparam int          DATA_W = 8;
    localparam int          PAIRS  = 2;
    localparam int          DEPTH  = 2;
    localparam int unsigned LENGTH = 6;
    localparam int          DRAIN  = 2;
    localparam int          PKT_W  = 2 * DATA_W * PAIRS;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              pkt_valid_i;
    logic              pkt_ready_o;
    logic [PKT_W-1:0]  pkt_data_i;
    logic              start_i;
    logic              loop_i;
    logic [DATA_W-1:0] a_o;
    logic [DATA_W-1:0] b_o;
    logic              op_valid_o;
    logic              op_ready_i;
    logic [DATA_W-1:0] res_i;
    logic              res_valid_i;
    logic [31:0]       count_o;
    logic [31:0]       checksum_o;
    logic              busy_o;
    logic              done_o;
    logic              underrun_o;

    pkt_operand_driver #(
        .DATA_W(DATA_W), .PAIRS(PAIRS), .DEPTH(DEPTH), .LENGTH(LENGTH), .DRAIN(DRAIN)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o), .pkt_data_i(pkt_data_i),
        .start_i(start_i), .loop_i(loop_i),
        .a_o(a_o), .b_o(b_o), .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .res_i(res_i), .res_valid_i(res_valid_i),
        .count_o(count_o), .checksum_o(checksum_o),
        .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic push_ok;

    logic [7:0] obs_a[$];
    logic [7:0] obs_b[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         hs_cyc[$];
    logic [7:0] res_log[int];

    // One cycle: inputs were set at the preceding negedge; sample #1 later,
    // record what the coming posedge will accept, then move to the next negedge.
    task automatic tick();
        #1;
        if (op_valid_o && op_ready_i) begin
            obs_a.push_back(a_o);
            obs_b.push_back(b_o);
            hs_cyc.push_back(cyc);
        end
        push_ok = pkt_valid_i && pkt_ready_o;
        if (res_valid_i) res_log[cyc] = res_i;
        @(negedge clk_i);
        cyc++;
    endtask

    // Expected stream: each packet contributes its pairs in order, reps times.
    task automatic add_pkt(input logic [31:0] p, input int reps);
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < PAIRS; k++) begin
                exp_a.push_back(p[2*k*8 +: 8]);
                exp_b.push_back(p[(2*k+1)*8 +: 8]);
            end
    endtask

    // Index of the first differing pair, or -1 when the streams agree.
    function automatic int seq_diff();
        int n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
        for (int i = 0; i < n; i++)
            if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) return i;
        if (obs_a.size() != exp_a.size()) return n;
        return -1;
    endfunction

    // Sum of logged results over cycles lo..hi, mod 2^32.
    function automatic logic [31:0] res_sum(input int lo, input int hi);
        logic [31:0] s = '0;
        for (int c = lo; c <= hi; c++)
            if (res_log.exists(c)) s += 32'(res_log[c]);
        return s;
    endfunction

    task automatic do_reset();
        pkt_valid_i = 0; pkt_data_i = '0; start_i = 0; loop_i = 0;
        op_ready_i = 0; res_i = '0; res_valid_i = 0;
        reset_i = 0;
        tick(); tick();
        reset_i = 1;
        tick();
        obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
        hs_cyc.delete(); res_log.delete();
    endtask

    task automatic push_pkt(input logic [31:0] p);
        int n = 0;
        pkt_valid_i = 1; pkt_data_i = p;
        do begin tick(); n++; end while (!push_ok && n < 20);
        pkt_valid_i = 0;
        if (!push_ok) begin
            checks++; failures++;
            $display("FAIL push_timeout pkt=%h not accepted in %0d cycles", p, n);
        end
    endtask

    task automatic start_run(output int s);
        start_i = 1; s = cyc;
        tick();
        start_i = 0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!done_o && n < bound) begin tick(); n++; end
        checks++;
        if (!done_o) begin
            failures++;
            $display("FAIL %s_timeout done_o=%b after %0d cycles", name, done_o, n);
        end
    endtask

    task automatic test_reset();
        int seen = 0;
        pkt_valid_i = 1; pkt_data_i = 32'hdeadbeef; start_i = 1; loop_i = 1;
        op_ready_i = 1; res_valid_i = 1; res_i = 8'h55;
        reset_i = 0;
        tick(); tick();
        checks++;
        if ({pkt_ready_o, op_valid_o, busy_o, done_o, underrun_o} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=10000",
                     {pkt_ready_o, op_valid_o, busy_o, done_o, underrun_o});
        end
        checks++;
        if (count_o !== 32'd0 || checksum_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters count=%0d checksum=%0d want 0/0", count_o, checksum_o);
        end
        checks++;
        if (a_o !== 8'd0 || b_o !== 8'd0) begin
            failures++;
            $display("FAIL reset_operands a=%h b=%h want 00/00", a_o, b_o);
        end
        pkt_valid_i = 0; start_i = 0; res_valid_i = 0;
        reset_i = 1;
        for (int i = 0; i < 6; i++) begin
            if (op_valid_o || busy_o || done_o) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_idle active_cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_loop();
        logic [31:0] p;
        int s, d, last;
        for (int it = 0; it < 2; it++) begin
            p = (it == 0) ? 32'h04030201 : $urandom;
            do_reset();
            push_pkt(p);
            loop_i = 1; op_ready_i = 1;
            start_run(s);
            wait_done("loop", 40);
            d = cyc;
            add_pkt(p, 3);
            checks++;
            d = seq_diff();
            if (d != -1) begin
                failures++;
                $display("FAIL loop_seq pkt=%h first_bad=%0d got_n=%0d want_n=%0d",
                         p, d, obs_a.size(), exp_a.size());
            end
            checks++;
            if (count_o !== 32'd6) begin
                failures++;
                $display("FAIL loop_count got=%0d want=6", count_o);
            end
            checks++;
            if (hs_cyc.size() != 6 || hs_cyc[0] != s + 2 || hs_cyc[5] != hs_cyc[0] + 5) begin
                failures++;
                $display("FAIL loop_timing hs_n=%0d first_offset=%0d want 6 consecutive from +2",
                         hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[0] - s : -1);
            end
            last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -100;
            checks++;
            if (cyc != last + 3 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL loop_done_delay done_seen_at=+%0d busy=%b want +3 busy 0",
                         cyc - last, busy_o);
            end
            tick(); tick(); tick();
            checks++;
            if (done_o !== 1'b1 || op_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL loop_done_hold done=%b op_valid=%b want 1/0", done_o, op_valid_o);
            end
        end
    endtask

    task automatic test_underrun();
        logic [31:0] p1, p2, p3;
        int s, n, pc, d;
        p1 = $urandom; p2 = $urandom; p3 = $urandom;
        do_reset();
        loop_i = 0; op_ready_i = 1;
        push_pkt(p1);
        start_run(s);
        n = 0;
        while (obs_a.size() < 2 && n < 20) begin tick(); n++; end
        tick();
        checks++;
        if (op_valid_o !== 1'b0 || underrun_o !== 1'b1 || count_o !== 32'd2) begin
            failures++;
            $display("FAIL underrun_stall op_valid=%b underrun=%b count=%0d want 0/1/2",
                     op_valid_o, underrun_o, count_o);
        end
        pc = cyc;
        push_pkt(p2);
        n = 0;
        while (!op_valid_o && n < 10) begin tick(); n++; end
        checks++;
        if (!op_valid_o || cyc - pc > 2 || a_o !== p2[7:0] || b_o !== p2[15:8]) begin
            failures++;
            $display("FAIL underrun_resume delay=%0d a=%h b=%h want <=2 %h/%h",
                     cyc - pc, a_o, b_o, p2[7:0], p2[15:8]);
        end
        n = 0;
        while (obs_a.size() < 4 && n < 20) begin tick(); n++; end
        tick();
        push_pkt(p3);
        wait_done("underrun", 40);
        add_pkt(p1, 1); add_pkt(p2, 1); add_pkt(p3, 1);
        checks++;
        d = seq_diff();
        if (d != -1) begin
            failures++;
            $display("FAIL underrun_seq first_bad=%0d got_n=%0d want_n=%0d",
                     d, obs_a.size(), exp_a.size());
        end
        checks++;
        if (count_o !== 32'd6 || underrun_o !== 1'b1) begin
            failures++;
            $display("FAIL underrun_end count=%0d underrun=%b want 6/1", count_o, underrun_o);
        end
    endtask

    task automatic test_backpressure();
        int pat[4] = '{1, 0, 0, 1};
        logic [31:0] p;
        logic [7:0]  pa, pb;
        logic [31:0] want;
        int s, k, n, d, hold_bad, last;
        logic prev_stall;
        for (int it = 0; it < 3; it++) begin
            p = $urandom;
            do_reset();
            push_pkt(p);
            loop_i = 1; op_ready_i = 1;
            res_valid_i = 1'($urandom_range(0, 1)); res_i = 8'($urandom);
            start_run(s);
            prev_stall = 0; hold_bad = 0; n = 0; pa = '0; pb = '0;
            while (!done_o && n < 200) begin
                k = cyc - (s + 2);
                op_ready_i  = (k < 0) ? 1'b1 : (k < 4) ? 1'(pat[k]) : 1'($urandom_range(0, 1));
                res_valid_i = 1'($urandom_range(0, 1));
                res_i       = 8'($urandom);
                if (prev_stall && (op_valid_o !== 1'b1 || a_o !== pa || b_o !== pb)) hold_bad++;
                prev_stall = op_valid_o && !op_ready_i;
                pa = a_o; pb = b_o;
                tick(); n++;
            end
            for (int i = 0; i < 3; i++) begin
                res_valid_i = 1'b1; res_i = 8'($urandom);
                tick();
            end
            res_valid_i = 0;
            checks++;
            if (!done_o) begin
                failures++;
                $display("FAIL bp_timeout done_o=%b after %0d cycles", done_o, n);
            end
            checks++;
            if (hold_bad != 0) begin
                failures++;
                $display("FAIL bp_hold unstable_stall_cycles=%0d want 0", hold_bad);
            end
            add_pkt(p, 3);
            checks++;
            d = seq_diff();
            if (d != -1) begin
                failures++;
                $display("FAIL bp_seq first_bad=%0d got_n=%0d want_n=%0d",
                         d, obs_a.size(), exp_a.size());
            end
            checks++;
            if (count_o !== 32'(obs_a.size()) || count_o !== 32'd6) begin
                failures++;
                $display("FAIL bp_count got=%0d handshakes=%0d want 6", count_o, obs_a.size());
            end
            last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : s;
            want = res_sum(s + 1, last + DRAIN);
            checks++;
            if (checksum_o !== want) begin
                failures++;
                $display("FAIL bp_checksum got=%h want=%h", checksum_o, want);
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] p0, p1, p2;
        int s, k, n, d, acc;
        logic pending;
        p0 = $urandom; p1 = $urandom; p2 = $urandom;
        do_reset();
        push_pkt(p0);
        push_pkt(p1);
        checks++;
        if (pkt_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full_ready got=%b want=0", pkt_ready_o);
        end
        pkt_valid_i = 1; pkt_data_i = p2; acc = 0;
        res_valid_i = 1; res_i = 8'h03;
        for (int i = 0; i < 3; i++) begin tick(); if (push_ok) acc++; end
        res_valid_i = 0;
        checks++;
        if (acc != 0 || pkt_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full_wait accepted=%0d ready=%b want 0/0", acc, pkt_ready_o);
        end
        loop_i = 0; op_ready_i = 1; pending = 1;
        res_valid_i = 1; res_i = 8'h03;
        start_run(s);
        if (push_ok) begin pending = 0; pkt_valid_i = 0; end
        n = 0;
        while (!done_o && n < 40) begin
            k = cyc - s;
            res_valid_i = (k >= 2 && k <= 7);
            res_i = 8'h03;
            tick(); n++;
            if (push_ok) begin pending = 0; pkt_valid_i = 0; end
        end
        res_valid_i = 1; res_i = 8'h03;
        tick(); tick();
        res_valid_i = 0; pkt_valid_i = 0;
        checks++;
        if (!done_o || pending) begin
            failures++;
            $display("FAIL fifo_run_end done=%b third_pending=%b want 1/0", done_o, pending);
        end
        add_pkt(p0, 1); add_pkt(p1, 1); add_pkt(p2, 1);
        checks++;
        d = seq_diff();
        if (d != -1 || hs_cyc.size() != 6 || hs_cyc[5] != hs_cyc[0] + 5) begin
            failures++;
            $display("FAIL fifo_seq first_bad=%0d hs_n=%0d want gapless 6", d, hs_cyc.size());
        end
        checks++;
        if (checksum_o !== 32'd18) begin
            failures++;
            $display("FAIL fifo_checksum got=%0d want=18", checksum_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int s, n, seen;
        do_reset();
        push_pkt($urandom);
        push_pkt($urandom);
        loop_i = 1; op_ready_i = 1;
        pkt_valid_i = 1; pkt_data_i = $urandom;
        start_run(s);
        n = 0;
        while (count_o != 32'd3 && n < 20) begin
            tick(); n++;
            if (push_ok) pkt_valid_i = 0;
        end
        pkt_valid_i = 0;
        checks++;
        if (count_o !== 32'd3) begin
            failures++;
            $display("FAIL midrst_reach count=%0d want 3", count_o);
        end
        reset_i = 0;
        #1;
        checks++;
        if ({pkt_ready_o, op_valid_o, busy_o, done_o, underrun_o} !== 5'b10000 ||
            count_o !== 32'd0 || checksum_o !== 32'd0 || a_o !== 8'd0 || b_o !== 8'd0) begin
            failures++;
            $display("FAIL midrst_outputs flags=%b count=%0d checksum=%0d a=%h b=%h want 10000/0/0/00/00",
                     {pkt_ready_o, op_valid_o, busy_o, done_o, underrun_o},
                     count_o, checksum_o, a_o, b_o);
        end
        @(negedge clk_i); cyc++;
        tick();
        reset_i = 1;
        tick();
        start_run(s);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (op_valid_o) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || busy_o !== 1'b1 || count_o !== 32'd0) begin
            failures++;
            $display("FAIL midrst_empty valid_cycles=%0d busy=%b count=%0d want 0/1/0",
                     seen, busy_o, count_o);
        end
    endtask

    initial begin
        reset_i = 0;
        pkt_valid_i = 0; pkt_data_i = '0; start_i = 0; loop_i = 0;
        op_ready_i = 0; res_i = '0; res_valid_i = 0;
        @(negedge clk_i);
        test_reset();
        test_loop();
        test_underrun();
        test_backpressure();
        test_fifo_full();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
